// File: rtl/fetch_queue_pkg.sv
// Shared constants and entry payload for the IFU-to-decode fetch queue.
// FETCHQ_PREDECODE_EN adds a control-transfer flag to each stored entry.
package fetch_queue_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;

  localparam logic [1:0] NPC_SEL_PC4 = 2'd0;
  localparam logic [1:0] NPC_SEL_BR  = 2'd1;
  localparam logic [1:0] NPC_SEL_J   = 2'd2;
  localparam logic [1:0] NPC_SEL_JR  = 2'd3;

  localparam logic [PC_W-1:0]    CODE_SEG_PC = 32'h0000_3000;
  localparam logic [INSTR_W-1:0] INSTR_NOP   = 32'h0000_0000;

  localparam logic [5:0] OPCODE_SPECIAL = 6'h00;
  localparam logic [5:0] OPCODE_J       = 6'h02;
  localparam logic [5:0] OPCODE_JAL     = 6'h03;
  localparam logic [5:0] OPCODE_BEQ     = 6'h04;
  localparam logic [5:0] FUNCT_JR       = 6'h08;

  typedef struct packed {
`ifdef FETCHQ_PREDECODE_EN
    logic               is_ctrl;
`endif
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_predecode.sv
// Combinational classifier: flags beq, j, jal and jr as control transfers.
module fetch_queue_predecode
  import fetch_queue_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic               is_ctrl
);

  logic [5:0] opcode;
  logic [5:0] funct;

  always_comb begin
    opcode  = instr[31:26];
    funct   = instr[5:0];
    is_ctrl = 1'b0;
    unique case (opcode)
      OPCODE_BEQ, OPCODE_J, OPCODE_JAL: is_ctrl = 1'b1;
      OPCODE_SPECIAL:                   is_ctrl = (funct == FUNCT_JR);
      default:                          is_ctrl = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_queue.sv
// In-order FIFO decoupling IFU from decode, with back-pressure and redirect flush.
// Optional FETCHQ_PREDECODE_EN adds out_is_ctrl per entry.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               in_ready,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
`ifdef FETCHQ_PREDECODE_EN
  output logic               out_is_ctrl,
`endif
  input  logic               out_ready,
  input  logic               flush,
  output logic [CNT_W-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  fq_entry_t        mem [DEPTH];
  fq_entry_t        wr_entry;
  fq_entry_t        head;
  logic             push;
  logic             pop;

  // Handshake decode from registered state only; flush masks both sides.
  always_comb begin
    in_ready  = (cnt_q != CNT_W'(DEPTH));
    out_valid = (cnt_q != '0) & ~flush;
    push      = in_valid & in_ready & ~flush;
    pop       = out_valid & out_ready;
  end

`ifdef FETCHQ_PREDECODE_EN
  logic in_is_ctrl;

  fetch_queue_predecode u_predecode (
    .instr   (in_instr),
    .is_ctrl (in_is_ctrl)
  );

  always_comb begin
    wr_entry.is_ctrl = in_is_ctrl;
    wr_entry.instr   = in_instr;
    wr_entry.pc      = in_pc;
  end
`else
  always_comb begin
    wr_entry.instr = in_instr;
    wr_entry.pc    = in_pc;
  end
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  // Pointers and occupancy; flush wins over any same-edge push/pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Bubble presentation when nothing valid is at the head.
  always_comb begin
    head      = mem[rd_ptr];
    count     = cnt_q;
    out_instr = out_valid ? head.instr : INSTR_NOP;
    out_pc    = out_valid ? head.pc    : CODE_SEG_PC;
`ifdef FETCHQ_PREDECODE_EN
    out_is_ctrl = out_valid & head.is_ctrl;
`endif
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=2); predecode checks under FETCHQ_PREDECODE_EN.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [31:0] BASE  = CODE_SEG_PC;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [31:0]      in_instr;
  logic [31:0]      in_pc;
  logic             in_ready;
  logic             out_valid;
  logic [31:0]      out_instr;
  logic [31:0]      out_pc;
  logic             out_ready;
  logic             flush;
  logic [CNT_W-1:0] count;
`ifdef FETCHQ_PREDECODE_EN
  logic             out_is_ctrl;
`endif

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  fetch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_pc    (out_pc),
`ifdef FETCHQ_PREDECODE_EN
    .out_is_ctrl (out_is_ctrl),
`endif
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_count"}, 64'(count), 64'd0);
    check({tag, "_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_instr"}, 64'(out_instr), 64'(INSTR_NOP));
    check({tag, "_pc"},    64'(out_pc), 64'(CODE_SEG_PC));
  endtask

  initial begin
    reset = 1'b0; out_ready = 1'b0; flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #12;
    check_idle("por");
    reset = 1'b1;
    tick();

    // Pass-through: each word visible one cycle after push, count holds at 1.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hA000_0000 + 32'(i), BASE + 32'(4 * i));
      tick();
      check($sformatf("pt%0d_pc", i), 64'(out_pc), 64'(BASE + 32'(4 * i)));
      check($sformatf("pt%0d_instr", i), 64'(out_instr), 64'(32'hA000_0000 + 32'(i)));
      check($sformatf("pt%0d_count", i), 64'(count), 64'd1);
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check_idle("pt_drain");

    // Fill with back-pressure; third word must be refused.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hB000_0000 + 32'(i), BASE + 32'(4 * i));
      tick();
    end
    check("full_count", 64'(count), 64'd2);
    check("full_ready", 64'(in_ready), 64'd0);
    check("full_head", 64'(out_pc), 64'(BASE));
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    tick();
    check("pop1_pc", 64'(out_pc), 64'(BASE + 32'd4));
    check("pop1_count", 64'(count), 64'd1);
    check("pop1_ready", 64'(in_ready), 64'd1);
    tick();
    check("pop2_valid", 64'(out_valid), 64'd0);
    check("pop2_count", 64'(count), 64'd0);

    // Simultaneous push and pop across pointer wrap.
    out_ready = 1'b0;
    drive(1'b1, 32'hC000_0000, BASE + 32'h100);
    tick();
    check("sim0_count", 64'(count), 64'd1);
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 32'hC000_0000 + 32'(k), BASE + 32'h100 + 32'(4 * k));
      tick();
      check($sformatf("sim%0d_count", k), 64'(count), 64'd1);
      check($sformatf("sim%0d_pc", k), 64'(out_pc), 64'(BASE + 32'h100 + 32'(4 * k)));
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("sim_drain_count", 64'(count), 64'd0);

    // Flush with a full queue and a concurrent in_valid word.
    out_ready = 1'b0;
    drive(1'b1, 32'hD000_0000, BASE + 32'h200);
    tick();
    drive(1'b1, 32'hD000_0001, BASE + 32'h204);
    tick();
    check("fl_pre_count", 64'(count), 64'd2);
    out_ready = 1'b1;
    flush = 1'b1;
    drive(1'b1, 32'hDEAD_0040, BASE + 32'h40 * 4);
    #1;
    check("fl_same_valid", 64'(out_valid), 64'd0);
    check("fl_same_pc", 64'(out_pc), 64'(CODE_SEG_PC));
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check_idle("fl_next");

    // Flush at count=1 while in_ready=1: same-cycle word still dropped.
    out_ready = 1'b0;
    drive(1'b1, 32'hE000_0000, BASE + 32'h300);
    tick();
    flush = 1'b1;
    drive(1'b1, 32'hDEAD_0041, BASE + 32'h40 * 4);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("fl1_count", 64'(count), 64'd0);
    drive(1'b1, 32'hE000_0001, BASE + 32'h304);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("fl1_post_pc", 64'(out_pc), 64'(BASE + 32'h304));
    check("fl1_post_count", 64'(count), 64'd1);
    out_ready = 1'b1;
    tick();

    // Asynchronous reset mid-cycle with two entries held.
    out_ready = 1'b0;
    drive(1'b1, 32'hF000_0000, BASE + 32'h400);
    tick();
    drive(1'b1, 32'hF000_0001, BASE + 32'h404);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("rst_pre_count", 64'(count), 64'd2);
    #2 reset = 1'b0;
    #1;
    check_idle("rst_mid");
    #1 reset = 1'b1;
    tick();
    check_idle("rst_after");

`ifdef FETCHQ_PREDECODE_EN
    begin
      logic [31:0] instrs [4];
      logic        exp_ctrl [4];
      instrs[0] = 32'h1000_0003; exp_ctrl[0] = 1'b1;
      instrs[1] = 32'h0800_0c10; exp_ctrl[1] = 1'b1;
      instrs[2] = 32'h03e0_0008; exp_ctrl[2] = 1'b1;
      instrs[3] = 32'h3c01_1234; exp_ctrl[3] = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        drive(1'b1, instrs[i], BASE + 32'h500 + 32'(4 * i));
        tick();
        check($sformatf("pd%0d_ctrl", i), 64'(out_is_ctrl), 64'(exp_ctrl[i]));
        check($sformatf("pd%0d_instr", i), 64'(out_instr), 64'(instrs[i]));
      end
      drive(1'b0, 32'h0, 32'h0);
      tick();
      check("pd_idle_ctrl", 64'(out_is_ctrl), 64'd0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling buffer between the IFU and the decode/controller stage.
- Captures each {instruction, pc} pair the IFU produces into a small FIFO and presents it in order to decode with a valid/ready handshake.
- Back-pressures the IFU via in_ready so that the PC holds while decode stalls.
- Discards all buffered entries on a redirect (taken beq, j, jr).

Parameters:
- DEPTH, 2, number of entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  IFU has a fetched word this cycle
- in_instr  input  32  IFU instruction
- in_pc  input  32  IFU pc
- in_ready  output  1  queue can accept; IFU holds PC when 0
- out_valid  output  1  head entry available to decode
- out_instr  output  32  head instruction
- out_pc  output  32  head pc
- out_ready  input  1  decode consumes head this cycle
- flush  input  1  redirect: drop all entries
- count  output  CNT_W  current occupancy

Behaviour:
- Reset (reset=0, asynchronous) clears wr_ptr, rd_ptr and count to 0. Outputs after reset:
  - out_valid=0, in_ready=1, count=0
  - out_instr=NOP (32'h0000_0000), out_pc=CODE_SEG_PC
- Reset asserted mid-operation discards all entries immediately, without waiting for clk.
- Handshakes:
  - push = in_valid & in_ready & ~flush
  - pop = out_valid & out_ready
  - Both sample on the rising edge of clk.
- in_ready = (count != DEPTH). It is combinational from registered state only; there is no same-cycle bypass from pop.
- out_valid = (count != 0) & ~flush.
- When out_valid=0, out_instr is forced to NOP and out_pc to CODE_SEG_PC, so decode sees a bubble.
- Latency: an entry pushed at edge N is visible on out_* after edge N (1 cycle). There is no combinational in->out path.
- Storage: DEPTH x 64-bit register array, written at wr_ptr on push and read at rd_ptr.
- Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH.
- count update per edge:
  - +1 on push only
  - -1 on pop only
  - unchanged on push&pop
- Full (count=DEPTH): in_ready=0, so no push occurs; a pop that cycle leaves count=DEPTH-1 and in_ready=1 next cycle.
- Empty: out_valid=0, so no pop occurs; a push that cycle gives count=1 next cycle.
- Flush has priority over push and pop:
  - On the edge where flush=1: ptrs=0, count=0; the same-cycle in_* word is discarded.
  - During the flush cycle, out_valid is 0 combinationally, so no pop is counted.
  - Next cycle: in_ready=1, out_valid=0.
- Order is strict FIFO; no entry is duplicated or reordered.
- The queue treats in_pc as opaque 32-bit data and performs no arithmetic on it.

Optional Feature:
- Macro: FETCHQ_PREDECODE_EN
- Defined:
  - Adds output out_is_ctrl (1 bit), registered alongside each entry at push.
  - out_is_ctrl=1 when in_instr opcode is beq (6'h04), j (6'h02), jal (6'h03), or SPECIAL (6'h00) with funct jr (6'h08). Otherwise 0.
  - Forced 0 when out_valid=0; reset value 0.
  - Storage width becomes 65 bits per entry.
- Undefined: port and storage bit are absent; all other behaviour is identical.

Decomposition:
- Shared macro header (alongside NPC_SEL_* and CODE_SEG_PC): INSTR_NOP, OPCODE_BEQ, OPCODE_J, OPCODE_JAL, OPCODE_SPECIAL, FUNCT_JR.
- One natural sub-module: fetch_queue_predecode, a combinational opcode/funct classifier instantiated only under FETCHQ_PREDECODE_EN.
- Storage and pointer logic stay inline.

Test Plan:
- Reset: assert reset=0 mid-run with 2 entries held -> immediately out_valid=0, count=0, in_ready=1, out_instr=32'h0, out_pc=CODE_SEG_PC.
- Pass-through: out_ready=1, push pc=CODE_SEG_PC+0,+4,+8 on consecutive cycles -> out_pc shows each one cycle later; count stays 1.
- Fill/back-pressure: out_ready=0, push 3 words with DEPTH=2 -> count=2, in_ready=0, third word not stored. Then raise out_ready -> pops in order +0, +4, and in_ready returns to 1 one cycle after the first pop.
- Simultaneous: count=1, push+pop same edge -> count stays 1, head advances to the new word; repeat 5 times across pointer wrap with no loss.
- Flush: count=2, flush=1 together with in_valid=1 (pc=CODE_SEG_PC+'h40*4) -> same cycle out_valid=0; next cycle count=0 and the +'h40*4 word is absent.
- Predecode (FETCHQ_PREDECODE_EN): push 32'h1000_0003 (beq), 32'h0800_0c10 (j), 32'h03e0_0008 (jr), 32'h3c01_1234 (lui) -> out_is_ctrl = 1,1,1,0.
